// File: rtl/fb_rect_fill_if.sv
// Command and frame-buffer write-port bundle for the rectangle fill engine.
// master drives commands and observes the BRAM port; slave is the fill engine itself.
interface fb_rect_fill_if #(
    parameter int X_BITS = 9,
    parameter int Y_BITS = 9
);
    logic              start;
    logic [X_BITS-1:0] x0;
    logic [X_BITS-1:0] x1;
    logic [Y_BITS-1:0] y0;
    logic [Y_BITS-1:0] y1;
    logic [7:0]        color;
    logic              busy;
    logic              done;
    logic              error;
    logic [31:0]       buffer_addr;
    logic [31:0]       buffer_din;
    logic              buffer_en;
    logic [3:0]        buffer_we;
    logic              buffer_rst;

    modport master (
        output start, x0, x1, y0, y1, color,
        input  busy, done, error, buffer_addr, buffer_din, buffer_en, buffer_we, buffer_rst
    );

    modport slave (
        input  start, x0, x1, y0, y1, color,
        output busy, done, error, buffer_addr, buffer_din, buffer_en, buffer_we, buffer_rst
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Fills an axis-aligned rectangle of the 400x300 RGB332 frame buffer with one colour,
// writing up to four packed pixels per cycle through byte enables.
module fb_rect_fill #(
    parameter int FB_WIDTH         = 400,
    parameter int FB_HEIGHT        = 300,
    parameter int X_BITS           = 9,
    parameter int Y_BITS           = 9,
    parameter int BUFFER_ADDR_BITS = 17
) (
    input  logic          clk,
    input  logic          reset_n,
    fb_rect_fill_if.slave bus
);
    localparam int CX_BITS = X_BITS + 1;
    localparam int AB      = BUFFER_ADDR_BITS;

    typedef enum logic [1:0] {IDLE, CHECK, FILL, DONE} state_t;

    state_t            state;
    logic [X_BITS-1:0] x0_l;
    logic [X_BITS-1:0] x1_l;
    logic [Y_BITS-1:0] y0_l;
    logic [Y_BITS-1:0] y1_l;
    logic [7:0]        color_l;

    // Cursor of the next word to write, and whether the word on the bus is the final one.
    logic [AB-1:0]      row_base;
    logic [CX_BITS-1:0] cur_x;
    logic [Y_BITS-1:0]  cur_y;
    logic               final_q;

    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic        en_q;
    logic [3:0]  we_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;

    logic               reject;
    logic [AB-1:0]      src_base;
    logic [CX_BITS-1:0] src_x;
    logic [Y_BITS-1:0]  src_y;
    logic [AB-1:0]      pix;
    logic [1:0]         off;
    logic [CX_BITS-1:0] span;
    int                 last_byte;
    logic [3:0]         we_n;
    logic [CX_BITS-1:0] step_x;
    logic               row_end;
    logic               final_n;
    logic [AB-1:0]      next_base;
    logic [CX_BITS-1:0] next_x;
    logic [Y_BITS-1:0]  next_y;

    always_comb begin
        reject = (x0_l > x1_l) || (y0_l > y1_l)
              || (32'(x1_l) >= 32'(FB_WIDTH)) || (32'(y1_l) >= 32'(FB_HEIGHT));
    end

    // The first word is generated straight from the latched command in CHECK, so the
    // only multiply lives there; later words come from the cursor registers.
    always_comb begin
        if (state == CHECK) begin
            src_base = AB'(y0_l) * AB'(FB_WIDTH);
            src_x    = CX_BITS'(x0_l);
            src_y    = y0_l;
        end else begin
            src_base = row_base;
            src_x    = cur_x;
            src_y    = cur_y;
        end

        pix       = src_base + AB'(src_x);
        off       = pix[1:0];
        span      = CX_BITS'(x1_l) - src_x;
        last_byte = int'(off) + int'(span);
        if (last_byte > 3) begin
            last_byte = 3;
        end

        we_n = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            we_n[n] = (n >= int'(off)) && (n <= last_byte);
        end

        step_x  = src_x + CX_BITS'(4 - int'(off));
        row_end = step_x > CX_BITS'(x1_l);
        final_n = row_end && (src_y == y1_l);

        if (row_end) begin
            next_base = src_base + AB'(FB_WIDTH);
            next_x    = CX_BITS'(x0_l);
            next_y    = src_y + Y_BITS'(1);
        end else begin
            next_base = src_base;
            next_x    = step_x;
            next_y    = src_y;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            x0_l     <= '0;
            x1_l     <= '0;
            y0_l     <= '0;
            y1_l     <= '0;
            color_l  <= '0;
            row_base <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            final_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            en_q     <= 1'b0;
            we_q     <= 4'b0000;
            addr_q   <= '0;
            din_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x0_l    <= bus.x0;
                        x1_l    <= bus.x1;
                        y0_l    <= bus.y0;
                        y1_l    <= bus.y1;
                        color_l <= bus.color;
                        busy_q  <= 1'b1;
                        state   <= CHECK;
                    end
                end
                CHECK, FILL: begin
                    if ((state == CHECK && reject) || (state == FILL && final_q)) begin
                        error_q <= (state == CHECK);
                        done_q  <= 1'b1;
                        en_q    <= 1'b0;
                        we_q    <= 4'b0000;
                        state   <= DONE;
                    end else begin
                        en_q     <= 1'b1;
                        we_q     <= we_n;
                        addr_q   <= 32'({pix[AB-1:2], 2'b00});
                        din_q    <= {4{color_l}};
                        row_base <= next_base;
                        cur_x    <= next_x;
                        cur_y    <= next_y;
                        final_q  <= final_n;
                        state    <= FILL;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.buffer_en   = en_q;
    assign bus.buffer_we   = we_q;
    assign bus.buffer_addr = addr_q;
    assign bus.buffer_din  = din_q;
    assign bus.buffer_rst  = 1'b0;
endmodule
